// File: rtl/i2c_master_write_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_master_write_if
// Description : Request/status and open-drain line bundle for i2c_master_write.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_master_write_if #(
    parameter int ADDR_W = 7
);
    logic              tick;
    logic              start;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              scl_in;
    logic              sda_in;
    logic              scl_oe;
    logic              sda_oe;
    logic              busy;
    logic              done;
    logic              ack_err;

    modport master (
        input  tick, start, addr, data, scl_in, sda_in,
        output scl_oe, sda_oe, busy, done, ack_err
    );

    modport slave (
        output tick, start, addr, data, scl_in, sda_in,
        input  scl_oe, sda_oe, busy, done, ack_err
    );
endinterface
`default_nettype wire

// File: rtl/i2c_master_write.sv
`default_nettype none
// ============================================================================
// Module      : i2c_master_write
// Description : Single-byte I2C write engine paced by a quarter-bit tick.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_master_write #(
    parameter int CLK_STRETCH = 1,
    parameter int ADDR_W      = 7
) (
    input  wire logic           clk,
    input  wire logic           rst,
    i2c_master_write_if.master  bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_ACK1  = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_ACK2  = 3'd5;
    localparam logic [2:0] S_STOP  = 3'd6;

    generate
        if (ADDR_W != 7) begin : g_addr_w_check
            $error("i2c_master_write supports only 7-bit addressing");
        end
    endgenerate

    logic [2:0] r_state;
    logic [1:0] r_phase;
    logic [2:0] r_bit;
    logic [7:0] r_shift;
    logic [7:0] r_data;
    logic       r_scl_oe;
    logic       r_sda_oe;
    logic       r_busy;
    logic       r_done;
    logic       r_ack_err;

    logic       w_bit_state;
    logic       w_ack_state;
    logic       w_stretch;
    logic       w_adv;
    logic       w_ack_sample;
    logic       w_accept;
    logic       w_fin;
    logic [2:0] w_state_n;
    logic [1:0] w_phase_n;
    logic [2:0] w_bit_n;
    logic       w_scl_oe_n;
    logic       w_sda_oe_n;

    assign w_bit_state  = (r_state == S_ADDR) || (r_state == S_DATA);
    assign w_ack_state  = (r_state == S_ACK1) || (r_state == S_ACK2);
    // A slave holding SCL low during the high half of a bit freezes the phase.
    assign w_stretch    = (CLK_STRETCH != 0) && (w_bit_state || w_ack_state)
                          && r_phase[1] && !bus.scl_in;
    assign w_adv        = bus.tick && !w_stretch;
    assign w_accept     = (r_state == S_IDLE) && bus.start;
    assign w_ack_sample = w_ack_state && w_adv && (r_phase == 2'd2) && bus.sda_in;

    always_comb begin
        w_state_n = r_state;
        w_phase_n = r_phase;
        w_bit_n   = r_bit;
        w_fin     = 1'b0;
        if (r_state == S_IDLE) begin
            if (bus.start) begin
                w_state_n = S_START;
                w_phase_n = 2'd0;
                w_bit_n   = 3'd7;
            end
        end else if (w_adv) begin
            w_phase_n = r_phase + 2'd1;
            if (r_phase == 2'd3) begin
                case (r_state)
                    S_START: begin
                        w_state_n = S_ADDR;
                        w_bit_n   = 3'd7;
                    end
                    S_ADDR: begin
                        if (r_bit == 3'd0) begin
                            w_state_n = S_ACK1;
                            w_bit_n   = 3'd7;
                        end else begin
                            w_bit_n = r_bit - 3'd1;
                        end
                    end
                    S_ACK1: begin
                        // r_ack_err was set by the sample at the end of phase 2.
                        w_state_n = r_ack_err ? S_STOP : S_DATA;
                        w_bit_n   = 3'd7;
                    end
                    S_DATA: begin
                        if (r_bit == 3'd0) begin
                            w_state_n = S_ACK2;
                            w_bit_n   = 3'd7;
                        end else begin
                            w_bit_n = r_bit - 3'd1;
                        end
                    end
                    S_ACK2: begin
                        w_state_n = S_STOP;
                    end
                    S_STOP: begin
                        w_state_n = S_IDLE;
                        w_fin     = 1'b1;
                    end
                    default: begin
                        w_state_n = S_IDLE;
                    end
                endcase
            end
        end
    end

    // Line drive is a function of the upcoming state/phase so it can be registered.
    always_comb begin
        w_scl_oe_n = 1'b0;
        w_sda_oe_n = 1'b0;
        case (w_state_n)
            S_START: begin
                w_sda_oe_n = w_phase_n[1];
                w_scl_oe_n = (w_phase_n == 2'd3);
            end
            S_ADDR: begin
                w_scl_oe_n = !w_phase_n[1];
                w_sda_oe_n = !r_shift[w_bit_n];
            end
            S_DATA: begin
                w_scl_oe_n = !w_phase_n[1];
                w_sda_oe_n = !r_data[w_bit_n];
            end
            S_ACK1, S_ACK2: begin
                w_scl_oe_n = !w_phase_n[1];
            end
            S_STOP: begin
                w_scl_oe_n = (w_phase_n == 2'd0);
                w_sda_oe_n = !w_phase_n[1];
            end
            default: begin
                w_scl_oe_n = 1'b0;
                w_sda_oe_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_phase   <= 2'd0;
            r_bit     <= 3'd7;
            r_shift   <= 8'd0;
            r_data    <= 8'd0;
            r_scl_oe  <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_phase  <= w_phase_n;
            r_bit    <= w_bit_n;
            r_scl_oe <= w_scl_oe_n;
            r_sda_oe <= w_sda_oe_n;
            r_busy   <= (w_state_n != S_IDLE);
            r_done   <= w_fin;
            if (w_accept) begin
                r_shift   <= {bus.addr, 1'b0};
                r_data    <= bus.data;
                r_ack_err <= 1'b0;
            end else if (w_ack_sample) begin
                r_ack_err <= 1'b1;
            end
        end
    end

    assign bus.scl_oe  = r_scl_oe;
    assign bus.sda_oe  = r_sda_oe;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.ack_err = r_ack_err;

endmodule
`default_nettype wire

// File: doc/i2c_master_write.md
Name: i2c_master_write

Overview:
- Byte-level I2C master write engine, directly downstream of `counter`.
- Consumes `counter`'s `isfull` pulse as its quarter-bit timing tick.
- Produces open-drain SCL/SDA controls for a single-byte write transaction: START, 7-bit address + W, ACK, data byte, ACK, STOP.
- Runs entirely in the `clk` domain. The tick is an enable, not a clock.

Parameters:
- `CLK_STRETCH`, default 1. When 1, SCL-high phases wait while `scl_in` is sampled low.
- `ADDR_W`, default 7. Slave address width. Only 7 is supported; any other value is a synthesis error.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: quarter-bit enable, connected to `counter.isfull`. Each cycle it is high counts as one tick.
- `start` in 1: transaction request. Sampled only in IDLE.
- `addr` in 7: slave address. Latched when `start` is accepted.
- `data` in 8: write byte. Latched when `start` is accepted.
- `scl_in` in 1: SCL line readback.
- `sda_in` in 1: SDA line readback.
- `scl_oe` out 1: 1 pulls SCL low; 0 releases it.
- `sda_oe` out 1: 1 pulls SDA low; 0 releases it.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle completion pulse.
- `ack_err` out 1: NACK seen in the last transaction. Held until the next accepted `start`.

Behaviour:
- Outputs:
  - All outputs are registered.
  - Reset values: `scl_oe`=0, `sda_oe`=0, `busy`=0, `done`=0, `ack_err`=0, state=IDLE, phase=0, bit index=7.
  - `rst` overrides everything, including mid-transaction: both lines are released on the next edge and no STOP is generated.
- Start handshake:
  - In IDLE, `start`=1 latches `{addr,1'b0}` into the shift register and `data` into the data register.
  - On the same edge: `busy`=1, `ack_err`=0, state=START, phase=0.
  - `start` while `busy` is ignored.
  - `tick` is ignored in IDLE.
- Phase counter:
  - 2-bit phase advances only on edges with `tick`=1, wrapping 3 to 0.
  - The state advances on the tick that ends phase 3.
- Bit timing (ADDR, DATA, ACK1, ACK2 states):
  - Phases 0–1: SCL low. SDA updates at phase 0 entry (`sda_oe` = ~bit).
  - Phases 2–3: SCL released.
  - Clock stretching: if `CLK_STRETCH`=1 and `scl_in`=0 during phase 2 or 3, ticks are ignored.
- START: SDA released and SCL released in phases 0–1; SDA low in phase 2; SCL low in phase 3.
- ADDR, then DATA:
  - 8 bits each, MSB first.
  - Bit index decrements at the end of each bit; after bit 0 the next state is ACK1 or ACK2 respectively.
- ACK1 and ACK2:
  - `sda_oe`=0 throughout.
  - `sda_in` is sampled on the tick ending phase 2. 1 means NACK: set `ack_err`.
  - ACK1 NACK: go to STOP, skipping DATA. ACK1 ACK: go to DATA.
  - ACK2: always go to STOP.
- STOP: phase 0 SCL low, SDA low; phase 1 SCL released; phase 2 SDA released; phase 3 hold.
- Completion:
  - On the tick ending STOP phase 3: state=IDLE, `busy`=0, `done`=1 for exactly one cycle.
  - `start` is sampled on that same edge only by the IDLE logic of the next cycle, so there is no back-to-back accept on the completion edge.
- Tick counts:
  - Successful transaction: 80 ticks (4 + 36 + 36 + 4).
  - Address NACK: 44 ticks.
- `tick` coinciding with `start` in IDLE does not advance the phase.

Test Plan:
- Normal write:
  - Stimulus: `addr`=0x50, `data`=0xA5, bench drives ACK (`sda_in`=0) in ACK windows, tick every 4th clk.
  - Required: SDA bit sequence 1,0,1,0,0,0,0,0 then 1,0,1,0,0,1,0,1.
  - Required: `done` pulses once, 320 clks after accept; `ack_err`=0; both `oe` outputs end at 0.
- Address NACK:
  - Stimulus: `sda_in`=1 at ACK1.
  - Required: no DATA bits, STOP follows, `done` after 44 ticks, `ack_err`=1 held until next `start`.
- Data NACK:
  - Stimulus: ACK at ACK1, NACK at ACK2.
  - Required: full 80 ticks, `ack_err`=1, STOP sequence present.
- Start while busy:
  - Stimulus: pulse `start` with `addr`=0x11 mid-DATA.
  - Required: transaction unchanged, a single `done`, latched address still 0x50.
- Clock stretch:
  - Stimulus: hold `scl_in`=0 for 10 ticks during bit 3 of ADDR, phase 2.
  - Required: phase frozen; completion delayed by exactly those 10 ticks.
- Reset mid-operation:
  - Stimulus: assert `rst` during DATA.
  - Required: next edge gives `scl_oe`=0, `sda_oe`=0, `busy`=0, no `done`; a fresh `start` then completes normally.
